// File: rtl/data_mem_ctrl.sv
// Single-port-per-direction data memory with a power-up / on-demand clear sweep.
// Optional macro DATA_MEM_CTRL_BYPASS_EN selects write-first forwarding on same-address read/write.
module data_mem_ctrl #(
    parameter int             W       = 8,
    parameter int             A       = 8,
    parameter logic [W-1:0]   CLR_VAL = '0
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         ClearReq,
    input  logic         WriteEn,
    input  logic [A-1:0] WrAddr,
    input  logic [W-1:0] WrData,
    input  logic         ReadEn,
    input  logic [A-1:0] RdAddr,
    output logic [W-1:0] RdData,
    output logic         RdValid,
    output logic         Busy
);

    localparam int DEPTH = 1 << A;

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_t;

    state_t         state_q, state_d;
    logic [A-1:0]   cnt_q, cnt_d;
    logic [W-1:0]   rd_data_q, rd_data_d;
    logic           rd_valid_q, rd_valid_d;

    logic [W-1:0]   core [DEPTH];

    logic           busy;
    logic           rd_accept;
    logic           wr_accept;
    logic           sweep_last;
    logic           mem_we;
    logic [A-1:0]   mem_waddr;
    logic [W-1:0]   mem_wdata;

    // Completion is an explicit compare on the last address, not a wrap detect.
    assign sweep_last = (cnt_q == {A{1'b1}});

    // State register
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; ClearReq during a sweep is deliberately ignored
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CLEAR: if (sweep_last) state_d = ST_READY;
            ST_READY: if (ClearReq)   state_d = ST_CLEAR;
            default:                  state_d = ST_CLEAR;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy      = (state_q == ST_CLEAR);
        rd_accept = (state_q == ST_READY) && ReadEn;
        wr_accept = (state_q == ST_READY) && WriteEn;
    end

    // Datapath next values
    always_comb begin
        cnt_d      = busy ? cnt_q + 1'b1 : '0;
        mem_we     = busy || wr_accept;
        mem_waddr  = busy ? cnt_q   : WrAddr;
        mem_wdata  = busy ? CLR_VAL : WrData;
        rd_valid_d = rd_accept;
        rd_data_d  = rd_data_q;
        if (rd_accept) begin
            rd_data_d = core[RdAddr];
`ifdef DATA_MEM_CTRL_BYPASS_EN
            if (wr_accept && (WrAddr == RdAddr)) begin
                rd_data_d = WrData;
            end
`endif
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cnt_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Array has no reset; the sweep initialises it.
    always_ff @(posedge Clk) begin
        if (mem_we) begin
            core[mem_waddr] <= mem_wdata;
        end
    end

    assign RdData  = rd_data_q;
    assign RdValid = rd_valid_q;
    assign Busy    = busy;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed scoreboard bench for data_mem_ctrl (W=8, A=4, CLR_VAL=8'hA5).
module tb_data_mem_ctrl;

`ifdef DATA_MEM_CTRL_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       Clk = 1'b0;
    logic       Reset;
    logic       ClearReq;
    logic       WriteEn;
    logic [3:0] WrAddr;
    logic [7:0] WrData;
    logic       ReadEn;
    logic [3:0] RdAddr;
    logic [7:0] RdData;
    logic       RdValid;
    logic       Busy;

    data_mem_ctrl #(.W(8), .A(4), .CLR_VAL(8'hA5)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .ClearReq (ClearReq),
        .WriteEn  (WriteEn),
        .WrAddr   (WrAddr),
        .WrData   (WrData),
        .ReadEn   (ReadEn),
        .RdAddr   (RdAddr),
        .RdData   (RdData),
        .RdValid  (RdValid),
        .Busy     (Busy)
    );

    always #5 Clk = ~Clk;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] m_mem [16];
    bit         m_busy;
    int         m_cnt;
    logic [7:0] q_exp [$];
    logic [7:0] last_rd;
    int         dut_busy_run;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply the current inputs to the model, take one edge, then check outputs.
    task automatic tick();
        bit         exp_valid;
        logic [7:0] e;
        exp_valid = 1'b0;
        if (Busy) dut_busy_run++;
        if (!Reset) begin
            m_busy = 1'b1;
            m_cnt  = 0;
        end else if (m_busy) begin
            m_mem[m_cnt] = 8'hA5;
            if (m_cnt == 15) begin
                m_busy = 1'b0;
                m_cnt  = 0;
            end else begin
                m_cnt++;
            end
        end else begin
            if (ReadEn) begin
                q_exp.push_back((BYP && WriteEn && (WrAddr == RdAddr)) ? WrData : m_mem[RdAddr]);
                exp_valid = 1'b1;
            end
            if (WriteEn) m_mem[WrAddr] = WrData;
            if (ClearReq) begin
                m_busy = 1'b1;
                m_cnt  = 0;
            end
        end
        @(posedge Clk);
        #1;
        chk("busy", Busy, m_busy);
        chk("rd_valid", RdValid, exp_valid);
        if (exp_valid) begin
            if (q_exp.size() == 0) begin
                chk("scoreboard_empty", 1, 0);
            end else begin
                e = q_exp.pop_front();
                chk("rd_data", RdData, e);
                last_rd = e;
            end
        end else begin
            chk("rd_hold", RdData, last_rd);
        end
    endtask

    task automatic idle_inputs();
        ClearReq = 1'b0;
        WriteEn  = 1'b0;
        ReadEn   = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (Busy && n < 40) begin
            tick();
            n++;
        end
        chk(tag, dut_busy_run, 16);
    endtask

    task automatic read_addr(input logic [3:0] a);
        ReadEn = 1'b1;
        RdAddr = a;
        tick();
        ReadEn = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) m_mem[i] = 8'hxx;
        Reset = 1'b0;
        idle_inputs();
        WrAddr = '0; WrData = '0; RdAddr = '0;
        m_busy = 1'b1; m_cnt = 0; last_rd = 8'h00; dut_busy_run = 0;

        // Reset state
        #3;
        chk("reset_rd_data", RdData, 8'h00);
        chk("reset_rd_valid", RdValid, 1'b0);
        chk("reset_busy", Busy, 1'b1);
        tick();
        tick();

        // Initial sweep after release, then read all addresses back to back
        Reset = 1'b1;
        dut_busy_run = 0;
        wait_ready("busy_len_init");
        for (int a = 0; a < 16; a++) read_addr(4'(a));
        tick();
        chk("final_sweep_read", RdData, 8'hA5);

        // Write then read, then idle hold
        WriteEn = 1'b1; WrAddr = 4'd7; WrData = 8'h3C;
        tick();
        WriteEn = 1'b0;
        read_addr(4'd7);
        chk("read_after_write", RdData, 8'h3C);
        tick();
        chk("idle_valid", RdValid, 1'b0);
        chk("idle_hold", RdData, 8'h3C);

        // Same-address read and write in one cycle
        WriteEn = 1'b1; WrAddr = 4'd2; WrData = 8'h11;
        ReadEn  = 1'b1; RdAddr = 4'd2;
        tick();
        idle_inputs();
        chk("same_addr_rw", RdData, BYP ? 8'h11 : 8'hA5);
        tick();
        read_addr(4'd2);
        chk("same_addr_later", RdData, 8'h11);

        // ClearReq with write and read in the same cycle, then disturbed sweep
        ClearReq = 1'b1;
        WriteEn = 1'b1; WrAddr = 4'd3; WrData = 8'hFF;
        ReadEn  = 1'b1; RdAddr = 4'd7;
        tick();
        chk("clear_read_preclear", RdData, 8'h3C);
        dut_busy_run = 0;
        for (int i = 0; i < 40 && Busy; i++) begin
            ClearReq = (i == 5);
            WriteEn  = 1'b1;
            WrAddr   = 4'($urandom_range(15, 0));
            WrData   = 8'($urandom_range(255, 0));
            ReadEn   = 1'b1;
            RdAddr   = 4'($urandom_range(15, 0));
            tick();
        end
        idle_inputs();
        chk("busy_len_clear", dut_busy_run, 16);
        read_addr(4'd3);
        chk("addr3_cleared", RdData, 8'hA5);
        read_addr(4'd7);
        chk("addr7_cleared", RdData, 8'hA5);

        // Reset in the middle of a sweep
        WriteEn = 1'b1; WrAddr = 4'd9; WrData = 8'h5A;
        tick();
        WriteEn = 1'b0;
        read_addr(4'd9);
        ClearReq = 1'b1;
        tick();
        ClearReq = 1'b0;
        repeat (9) tick();
        Reset = 1'b0;
        #1;
        chk("midsweep_rd_data", RdData, 8'h00);
        chk("midsweep_rd_valid", RdValid, 1'b0);
        chk("midsweep_busy", Busy, 1'b1);
        last_rd = 8'h00;
        q_exp.delete();
        tick();
        tick();
        Reset = 1'b1;
        dut_busy_run = 0;
        wait_ready("busy_len_rst");
        read_addr(4'd9);
        chk("addr9_after_rst", RdData, 8'hA5);
        read_addr(4'd2);
        chk("addr2_after_rst", RdData, 8'hA5);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter W, default 8, data word width in bits (1..64).
REQ-002 Parameter A, default 8, address width in bits; depth = 2**A words (1..12).
REQ-003 Parameter CLR_VAL, default 0, W-bit value written to every word by a clear sweep.
REQ-004 Clk  input  1  single clock; all state updates on posedge Clk.
REQ-005 Reset  input  1  asynchronous, active-low reset.
REQ-006 ClearReq  input  1  request a full-memory clear sweep.
REQ-007 WriteEn  input  1  write strobe.
REQ-008 WrAddr  input  A  write address.
REQ-009 WrData  input  W  write data.
REQ-010 ReadEn  input  1  read strobe.
REQ-011 RdAddr  input  A  read address, independent of WrAddr.
REQ-012 RdData  output  W  registered read data.
REQ-013 RdValid  output  1  RdData updated by an accepted read this cycle.
REQ-014 Busy  output  1  clear sweep in progress; accesses ignored.

Function
REQ-015 FSM has two states, CLEAR and READY; Busy SHALL be 1 exactly when state is CLEAR.
REQ-016 In CLEAR, one word per cycle: Core[cnt] <= CLR_VAL, cnt increments from 0 to 2**A-1, then state goes to READY on the following edge.
REQ-017 A full sweep SHALL take exactly 2**A cycles in CLEAR; cnt is A bits wide and is not used to detect completion by wrap-around alone.
REQ-018 In READY, ClearReq=1 SHALL move state to CLEAR with cnt=0 on the next edge.
REQ-019 ClearReq while in CLEAR SHALL be ignored; the sweep neither restarts nor extends.
REQ-020 In READY, WriteEn=1 SHALL write WrData to Core[WrAddr] at the edge.
REQ-021 In READY, ReadEn=1 SHALL load RdData with Core[RdAddr] and set RdValid=1 on the next edge (latency 1 cycle).
REQ-022 RdValid SHALL be 0 in any cycle following one with no accepted read; RdData SHALL hold its last value when no read is accepted.
REQ-023 In CLEAR, WriteEn and ReadEn SHALL be ignored: no memory write, RdValid stays 0, RdData holds.
REQ-024 ClearReq and WriteEn in the same READY cycle: the write SHALL occur, then the sweep overwrites it with CLR_VAL.
REQ-025 ClearReq and ReadEn in the same READY cycle: the read SHALL be accepted and return pre-clear data.
REQ-026 Back-to-back reads every cycle SHALL each return data with RdValid held at 1.
REQ-027 Read and write of the same address in the same READY cycle: behaviour per REQ-032/REQ-033.

Reset
REQ-028 Reset low SHALL immediately force state=CLEAR, cnt=0, RdData=0, RdValid=0, Busy=1.
REQ-029 Memory array contents SHALL NOT be reset asynchronously; they are initialised by the sweep after Reset rises.
REQ-030 Reset asserted mid-sweep SHALL restart the sweep from address 0 after release.
REQ-031 After Reset rises, the first accepted access SHALL be possible 2**A cycles later.

Configuration
REQ-032 With macro DATA_MEM_CTRL_BYPASS_EN defined, a same-cycle read and write to the same address SHALL return WrData on RdData (write-first forwarding).
REQ-033 Without DATA_MEM_CTRL_BYPASS_EN, the same case SHALL return the word's prior content (read-first); the write still completes.

Verification (bench uses W=8, A=4, CLR_VAL=8'hA5)
REQ-034 Release Reset -> Busy=1 for exactly 16 cycles, then 0; reading all 16 addresses returns 8'hA5 with RdValid=1 one cycle after each ReadEn.
REQ-035 Write 8'h3C to addr 7, next cycle read addr 7 -> RdData=8'h3C, RdValid=1 one cycle after ReadEn; idle cycle -> RdValid=0, RdData still 8'h3C.
REQ-036 Write 8'h11 to addr 2 and read addr 2 in the same cycle (prior 8'hA5) -> RdData=8'h11 with BYPASS_EN, 8'hA5 without; later read returns 8'h11 in both builds.
REQ-037 ClearReq with WriteEn of 8'hFF to addr 3 in the same cycle; ClearReq re-pulsed at sweep cycle 5; WriteEn/ReadEn during sweep -> Busy exactly 16 cycles, no RdValid during sweep, addr 3 reads 8'hA5 afterward.
REQ-038 Pull Reset low at sweep cycle 9 for 2 cycles -> RdData=0, RdValid=0 immediately; Busy then lasts exactly 16 cycles after release.
